// File: rtl/exec_pkg.sv
// exec_pkg: shared codes for the execute stage.
//   ALU op codes, branch funct3 codes, forward selects, ResultSrc codes, multiplier FSM states.
package exec_pkg;
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;
   localparam logic [1:0] FWD_E = 2'b00;
   localparam logic [1:0] FWD_W = 2'b01;
   localparam logic [1:0] FWD_M = 2'b10;
   localparam logic [1:0] RS_ALU = 2'b00;
   localparam logic [1:0] RS_MEM = 2'b01;
   localparam logic [1:0] RS_PC4 = 2'b10;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} mul_state_t;
endpackage

// File: rtl/execute_cycle_ext_if.sv
// execute_cycle_ext_if: bundle between decode/writeback and the execute stage.
//   master drives decoded E controls, operands, forwarding selects, FlushE, ResultW;
//   slave (execute stage) drives redirect, StallE and the M-stage register outputs.
interface execute_cycle_ext_if #(parameter int XLEN = 32, parameter int RA_W = 5);
   logic            ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, MulE, FlushE;
   logic [1:0]      ResultSrcE, ForwardAE, ForwardBE;
   logic [3:0]      ALUControlE;
   logic [2:0]      BrFunct3E;
   logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [RA_W-1:0] RD_E;
   logic            PCSrcE, StallE, RegWriteM, MemWriteM;
   logic [XLEN-1:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
   logic [1:0]      ResultSrcM;
   logic [RA_W-1:0] RD_M;
   modport master (
      output ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, MulE, FlushE,
             ResultSrcE, ForwardAE, ForwardBE, ALUControlE, BrFunct3E,
             RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E,
      input  PCSrcE, StallE, RegWriteM, MemWriteM, PCTargetE, ALU_ResultM, WriteDataM,
             PCPlus4M, ResultSrcM, RD_M
   );
   modport slave (
      input  ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, MulE, FlushE,
             ResultSrcE, ForwardAE, ForwardBE, ALUControlE, BrFunct3E,
             RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, RD_E,
      output PCSrcE, StallE, RegWriteM, MemWriteM, PCTargetE, ALU_ResultM, WriteDataM,
             PCPlus4M, ResultSrcM, RD_M
   );
endinterface

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier returning the low XLEN product bits.
//   clk, rst (async active-low), start_i (accept operands in IDLE), flush_i (abort to IDLE),
//   a_i/b_i operands, state_o (IDLE/BUSY/DONE), prod_o (valid while DONE).
module mul_iter import exec_pkg::*; #(parameter int XLEN = 32) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output mul_state_t      state_o,
   output logic [XLEN-1:0] prod_o
);
   localparam int CW = $clog2(XLEN);
   mul_state_t      state_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] a_q, b_q, acc_q;
   // a_q shifts right to expose the next multiplier bit, b_q shifts left as the weighted addend
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else if (flush_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else
         case (state_q)
            S_IDLE: if (start_i) begin
               state_q <= S_BUSY;
               cnt_q   <= '0;
               a_q     <= a_i;
               b_q     <= b_i;
               acc_q   <= '0;
            end
            S_BUSY: begin
               acc_q <= a_q[0] ? acc_q + b_q : acc_q;
               a_q   <= a_q >> 1;
               b_q   <= b_q << 1;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN - 1)) state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
   assign state_o = state_q;
   assign prod_o  = acc_q;
endmodule

// File: rtl/execute_cycle_ext.sv
// execute_cycle_ext: RV32I execute stage with forwarding, branch/jump resolution, flush and iterative MUL.
//   clk, rst (async active-low), bus (execute_cycle_ext_if.slave): E inputs in, redirect/StallE/M register out.
module execute_cycle_ext import exec_pkg::*; #(parameter int XLEN = 32, parameter int RA_W = 5) (
   input logic                clk,
   input logic                rst,
   execute_cycle_ext_if.slave bus
);
   localparam int SW = $clog2(XLEN);
   logic [XLEN-1:0] src_a, fwd_b, src_b, alu, prod;
   logic [SW-1:0]   shamt;
   logic            taken, start, stall, load_mul, bubble;
   mul_state_t      state;
   logic [RA_W-1:0] mul_rd_q, rd_q;
   logic            mul_rw_q, regw_q, memw_q;
   logic [1:0]      rsrc_q;
   logic [XLEN-1:0] alu_q, wd_q, pc4_q;
   // select code 11 falls through to the register-file operand
   assign src_a = (bus.ForwardAE == FWD_W) ? bus.ResultW : (bus.ForwardAE == FWD_M) ? alu_q : bus.RD1_E;
   assign fwd_b = (bus.ForwardBE == FWD_W) ? bus.ResultW : (bus.ForwardBE == FWD_M) ? alu_q : bus.RD2_E;
   assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
   assign shamt = src_b[SW-1:0];
   always_comb begin
      alu = '0;
      case (bus.ALUControlE)
         ALU_ADD:  alu = src_a + src_b;
         ALU_SUB:  alu = src_a - src_b;
         ALU_AND:  alu = src_a & src_b;
         ALU_OR:   alu = src_a | src_b;
         ALU_XOR:  alu = src_a ^ src_b;
         ALU_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         ALU_SLTU: alu = {{(XLEN-1){1'b0}}, src_a < src_b};
         ALU_SLL:  alu = src_a << shamt;
         ALU_SRL:  alu = src_a >> shamt;
         ALU_SRA:  alu = XLEN'($signed(src_a) >>> shamt);
         default:  alu = '0;
      endcase
   end
   always_comb begin
      taken = 1'b0;
      case (bus.BrFunct3E)
         BR_EQ:   taken = src_a == fwd_b;
         BR_NE:   taken = src_a != fwd_b;
         BR_LT:   taken = $signed(src_a) < $signed(fwd_b);
         BR_GE:   taken = $signed(src_a) >= $signed(fwd_b);
         BR_LTU:  taken = src_a < fwd_b;
         BR_GEU:  taken = src_a >= fwd_b;
         default: taken = 1'b0;
      endcase
   end
   assign bus.PCSrcE    = bus.ValidE & ~bus.FlushE & (bus.JumpE | bus.JalrE | (bus.BranchE & taken));
   assign bus.PCTargetE = bus.JalrE ? (src_a + bus.Imm_Ext_E) & ~XLEN'(1) : bus.PCE + bus.Imm_Ext_E;
   assign start    = (state == S_IDLE) & bus.ValidE & bus.MulE & ~bus.FlushE;
   assign stall    = rst & (start | (state == S_BUSY));
   assign load_mul = (state == S_DONE) & ~bus.FlushE;
   // in DONE the still-presented mul is not executed as a normal op
   assign bubble   = stall | bus.FlushE | ~bus.ValidE | (state == S_DONE);
   assign bus.StallE = stall;
   mul_iter #(.XLEN(XLEN)) u_mul (
      .clk(clk), .rst(rst), .start_i(start), .flush_i(bus.FlushE),
      .a_i(src_a), .b_i(fwd_b), .state_o(state), .prod_o(prod)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mul_rd_q <= '0;
         mul_rw_q <= 1'b0;
      end else if (start) begin
         mul_rd_q <= bus.RD_E;
         mul_rw_q <= bus.RegWriteE;
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         {regw_q, memw_q, rsrc_q, rd_q, alu_q, wd_q, pc4_q} <= '0;
      end else if (load_mul) begin
         {regw_q, memw_q, rsrc_q, rd_q} <= {mul_rw_q, 1'b0, RS_ALU, mul_rd_q};
         {alu_q, wd_q, pc4_q}           <= {prod, {XLEN{1'b0}}, {XLEN{1'b0}}};
      end else if (bubble) begin
         {regw_q, memw_q, rsrc_q, rd_q, alu_q, wd_q, pc4_q} <= '0;
      end else begin
         {regw_q, memw_q, rsrc_q, rd_q} <= {bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.RD_E};
         {alu_q, wd_q, pc4_q}           <= {alu, fwd_b, bus.PCPlus4E};
      end
   assign bus.RegWriteM   = regw_q;
   assign bus.MemWriteM   = memw_q;
   assign bus.ResultSrcM  = rsrc_q;
   assign bus.RD_M        = rd_q;
   assign bus.ALU_ResultM = alu_q;
   assign bus.WriteDataM  = wd_q;
   assign bus.PCPlus4M    = pc4_q;
endmodule

// File: tb/tb_execute_cycle_ext.sv
// tb_execute_cycle_ext: directed self-checking bench for execute_cycle_ext.
module tb_execute_cycle_ext;
   import exec_pkg::*;
   localparam int XLEN = 32;
   localparam int RA_W = 5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   execute_cycle_ext_if #(.XLEN(XLEN), .RA_W(RA_W)) bus();
   execute_cycle_ext #(.XLEN(XLEN), .RA_W(RA_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic clear_in();
      {bus.ValidE, bus.RegWriteE, bus.MemWriteE, bus.ALUSrcE, bus.BranchE, bus.JumpE, bus.JalrE, bus.MulE, bus.FlushE} = '0;
      {bus.ResultSrcE, bus.ForwardAE, bus.ForwardBE, bus.ALUControlE, bus.BrFunct3E} = '0;
      {bus.RD1_E, bus.RD2_E, bus.Imm_Ext_E, bus.PCE, bus.PCPlus4E, bus.ResultW} = '0;
      bus.RD_E = '0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [3*XLEN+RA_W+3:0] m_all();
      return {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M, bus.ALU_ResultM, bus.WriteDataM, bus.PCPlus4M};
   endfunction
   task automatic test_reset();
      clear_in();
      #2 rst = 1'b0;
      tick(); tick();
      tests++; if (m_all() !== '0) begin fails++; $display("FAIL reset_m: got %h exp 0", m_all()); end
      bus.ValidE = 1'b1; bus.JumpE = 1'b1; bus.MulE = 1'b1; bus.PCE = 32'h40; bus.Imm_Ext_E = 32'h8;
      #1;
      tests++; if (bus.StallE !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b exp 0", bus.StallE); end
      tests++; if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'h48) begin fails++; $display("FAIL reset_pcsrc: got %b %h exp 1 00000048", bus.PCSrcE, bus.PCTargetE); end
      clear_in();
      tick();
      rst = 1'b1;
      tick();
      tests++; if (m_all() !== '0) begin fails++; $display("FAIL reset_release: got %h exp 0", m_all()); end
   endtask
   task automatic test_alu();
      clear_in();
      bus.ValidE = 1'b1; bus.RegWriteE = 1'b1; bus.ALUSrcE = 1'b1; bus.RD_E = 5'd5;
      bus.ALUControlE = ALU_ADD; bus.RD1_E = 32'h7FFFFFFF; bus.Imm_Ext_E = 32'h1;
      tick();
      tests++; if (bus.ALU_ResultM !== 32'h80000000) begin fails++; $display("FAIL add: got %h exp 80000000", bus.ALU_ResultM); end
      tests++; if (bus.RegWriteM !== 1'b1 || bus.RD_M !== 5'd5) begin fails++; $display("FAIL add_ctl: got %b %0d exp 1 5", bus.RegWriteM, bus.RD_M); end
      bus.ALUControlE = ALU_SRA; bus.RD1_E = 32'h80000000; bus.Imm_Ext_E = 32'h24;
      tick();
      tests++; if (bus.ALU_ResultM !== 32'hF8000000) begin fails++; $display("FAIL sra: got %h exp f8000000", bus.ALU_ResultM); end
      bus.ALUControlE = ALU_SLT; bus.ALUSrcE = 1'b0; bus.RD1_E = 32'hFFFFFFFF; bus.RD2_E = 32'h1;
      tick();
      tests++; if (bus.ALU_ResultM !== 32'h1) begin fails++; $display("FAIL slt: got %h exp 1", bus.ALU_ResultM); end
      bus.ALUControlE = ALU_SLTU;
      tick();
      tests++; if (bus.ALU_ResultM !== 32'h0) begin fails++; $display("FAIL sltu: got %h exp 0", bus.ALU_ResultM); end
   endtask
   task automatic test_branch();
      clear_in();
      bus.ValidE = 1'b1; bus.BranchE = 1'b1; bus.BrFunct3E = BR_LT;
      bus.RD1_E = 32'hFFFFFFFF; bus.RD2_E = 32'h1; bus.PCE = 32'h100; bus.Imm_Ext_E = 32'h20;
      #1;
      tests++; if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'h120) begin fails++; $display("FAIL blt: got %b %h exp 1 00000120", bus.PCSrcE, bus.PCTargetE); end
      bus.BrFunct3E = BR_LTU; #1;
      tests++; if (bus.PCSrcE !== 1'b0) begin fails++; $display("FAIL bltu: got %b exp 0", bus.PCSrcE); end
      bus.BrFunct3E = BR_GEU; #1;
      tests++; if (bus.PCSrcE !== 1'b1) begin fails++; $display("FAIL bgeu: got %b exp 1", bus.PCSrcE); end
      bus.RD1_E = 32'h5; bus.RD2_E = 32'h5; bus.BrFunct3E = 3'b011; #1;
      tests++; if (bus.PCSrcE !== 1'b0) begin fails++; $display("FAIL br_011: got %b exp 0", bus.PCSrcE); end
      bus.BrFunct3E = BR_EQ; #1;
      tests++; if (bus.PCSrcE !== 1'b1) begin fails++; $display("FAIL beq: got %b exp 1", bus.PCSrcE); end
      bus.ValidE = 1'b0; #1;
      tests++; if (bus.PCSrcE !== 1'b0) begin fails++; $display("FAIL br_invalid: got %b exp 0", bus.PCSrcE); end
      bus.ValidE = 1'b1; bus.FlushE = 1'b1; bus.RegWriteE = 1'b1; #1;
      tests++; if (bus.PCSrcE !== 1'b0) begin fails++; $display("FAIL br_flush: got %b exp 0", bus.PCSrcE); end
      tick();
      tests++; if (bus.RegWriteM !== 1'b0) begin fails++; $display("FAIL flush_bubble: got %b exp 0", bus.RegWriteM); end
   endtask
   task automatic test_jalr();
      clear_in();
      bus.ValidE = 1'b1; bus.JalrE = 1'b1; bus.ALUSrcE = 1'b1; bus.RegWriteE = 1'b1; bus.RD_E = 5'd1;
      bus.RD1_E = 32'h1003; bus.Imm_Ext_E = 32'h4; bus.PCE = 32'h200; bus.PCPlus4E = 32'h204; bus.ResultSrcE = RS_PC4;
      #1;
      tests++; if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'h1006) begin fails++; $display("FAIL jalr: got %b %h exp 1 00001006", bus.PCSrcE, bus.PCTargetE); end
      tick();
      tests++; if (bus.PCPlus4M !== 32'h204 || bus.ResultSrcM !== RS_PC4) begin fails++; $display("FAIL jalr_m: got %h %b exp 00000204 10", bus.PCPlus4M, bus.ResultSrcM); end
   endtask
   task automatic test_forward();
      clear_in();
      bus.ValidE = 1'b1; bus.RegWriteE = 1'b1; bus.ALUSrcE = 1'b1; bus.RD_E = 5'd3;
      bus.ALUControlE = ALU_ADD; bus.RD1_E = 32'h2; bus.Imm_Ext_E = 32'h3;
      tick();
      tests++; if (bus.ALU_ResultM !== 32'h5) begin fails++; $display("FAIL fwd_setup: got %h exp 5", bus.ALU_ResultM); end
      bus.ALUSrcE = 1'b0; bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b1; bus.ALUControlE = ALU_SUB;
      bus.ForwardAE = FWD_M; bus.ForwardBE = FWD_W; bus.ResultW = 32'h7; bus.RD1_E = 32'h55; bus.RD2_E = 32'h66;
      tick();
      tests++; if (bus.ALU_ResultM !== 32'hFFFFFFFE) begin fails++; $display("FAIL fwd_sub: got %h exp fffffffe", bus.ALU_ResultM); end
      tests++; if (bus.WriteDataM !== 32'h7 || bus.MemWriteM !== 1'b1) begin fails++; $display("FAIL fwd_wd: got %h %b exp 7 1", bus.WriteDataM, bus.MemWriteM); end
      bus.ForwardAE = 2'b11; bus.ForwardBE = FWD_E; bus.RD1_E = 32'h10; bus.RD2_E = 32'h4;
      tick();
      tests++; if (bus.ALU_ResultM !== 32'hC) begin fails++; $display("FAIL fwd_11: got %h exp c", bus.ALU_ResultM); end
   endtask
   task automatic test_mul();
      int cnt = 0;
      logic bad = 1'b0;
      clear_in();
      bus.ValidE = 1'b1; bus.MulE = 1'b1; bus.RegWriteE = 1'b1; bus.RD_E = 5'd9;
      bus.RD1_E = 32'hFFFFFFFF; bus.RD2_E = 32'h3;
      #1;
      for (int i = 0; i < 100 && bus.StallE === 1'b1; i++) begin
         cnt++;
         tick();
         if (bus.RegWriteM !== 1'b0 || bus.MemWriteM !== 1'b0) bad = 1'b1;
      end
      tests++; if (cnt != 33) begin fails++; $display("FAIL mul_stall_len: got %0d exp 33", cnt); end
      tests++; if (bad) begin fails++; $display("FAIL mul_bubbles: got write during stall exp none"); end
      tick();
      tests++; if (bus.ALU_ResultM !== 32'hFFFFFFFD) begin fails++; $display("FAIL mul_result: got %h exp fffffffd", bus.ALU_ResultM); end
      tests++; if (bus.RD_M !== 5'd9 || bus.RegWriteM !== 1'b1 || bus.ResultSrcM !== RS_ALU) begin fails++; $display("FAIL mul_ctl: got %0d %b %b exp 9 1 00", bus.RD_M, bus.RegWriteM, bus.ResultSrcM); end
      clear_in();
      tick();
      tests++; if (bus.StallE !== 1'b0 || bus.RegWriteM !== 1'b0) begin fails++; $display("FAIL mul_after: got %b %b exp 0 0", bus.StallE, bus.RegWriteM); end
   endtask
   task automatic test_mul_flush();
      logic bad = 1'b0;
      clear_in();
      bus.ValidE = 1'b1; bus.MulE = 1'b1; bus.RegWriteE = 1'b1; bus.RD_E = 5'd4;
      bus.RD1_E = 32'h5; bus.RD2_E = 32'h6;
      #1;
      tests++; if (bus.StallE !== 1'b1) begin fails++; $display("FAIL flush_start: got %b exp 1", bus.StallE); end
      repeat (10) tick();
      bus.FlushE = 1'b1; bus.ValidE = 1'b0; bus.MulE = 1'b0;
      tick();
      tests++; if (bus.StallE !== 1'b0 || bus.RegWriteM !== 1'b0) begin fails++; $display("FAIL flush_drop: got %b %b exp 0 0", bus.StallE, bus.RegWriteM); end
      bus.FlushE = 1'b0;
      repeat (40) begin
         tick();
         if (bus.RegWriteM !== 1'b0 || bus.StallE !== 1'b0) bad = 1'b1;
      end
      tests++; if (bad) begin fails++; $display("FAIL flush_nowrite: got write or stall exp none"); end
   endtask
   task automatic test_reset_mid_mul();
      logic bad = 1'b0;
      clear_in();
      bus.ValidE = 1'b1; bus.RegWriteE = 1'b1; bus.ALUSrcE = 1'b1; bus.RD_E = 5'd2; bus.RD1_E = 32'h1; bus.Imm_Ext_E = 32'h1;
      tick();
      tests++; if (bus.RegWriteM !== 1'b1 || bus.ALU_ResultM !== 32'h2) begin fails++; $display("FAIL rmm_setup: got %b %h exp 1 2", bus.RegWriteM, bus.ALU_ResultM); end
      bus.ALUSrcE = 1'b0; bus.MulE = 1'b1; bus.RD_E = 5'd8; bus.RD1_E = 32'h7; bus.RD2_E = 32'h7;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      tests++; if (m_all() !== '0 || bus.StallE !== 1'b0) begin fails++; $display("FAIL rmm_reset: got %h %b exp 0 0", m_all(), bus.StallE); end
      clear_in();
      tick();
      rst = 1'b1;
      repeat (40) begin
         tick();
         if (bus.RegWriteM !== 1'b0 || bus.StallE !== 1'b0) bad = 1'b1;
      end
      tests++; if (bad) begin fails++; $display("FAIL rmm_nowrite: got write or stall exp none"); end
   endtask
   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_jalr();
      test_forward();
      test_mul();
      test_mul_flush();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
